// File: rtl/memcore_pkg.sv
// rtl/memcore_pkg.sv - shared types and helpers for the memcore read-side stream blocks
package memcore_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BURST      = 2'd1,
      DRAIN_DONE = 2'd2
   } state_t;

   localparam int MAX_READ_LATENCY = 4;

   // Sequential address step that wraps at the end of the memcore.
   function automatic int unsigned addr_next(input int unsigned addr, input int unsigned range);
      return (addr + 1 >= range) ? 0 : addr + 1;
   endfunction

   // Buffer must hold every in-flight read plus one, and pointers wrap by power of two.
   function automatic bit buf_depth_ok(input int depth, input int latency);
      return (latency >= 1) && (latency <= MAX_READ_LATENCY) &&
             (depth >= latency + 1) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/memcore_stream_buf.sv
// rtl/memcore_stream_buf.sv - register-based first-word-fall-through buffer with occupancy
module memcore_stream_buf
   import memcore_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        push_data,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        head_data,
   output logic                         head_valid,
   output logic [$clog2(BUF_DEPTH):0]   occupancy
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  do_pop;
   logic                  do_push;

   assign do_pop     = pop && (count != '0);
   assign do_push    = push && ((count != CW'(BUF_DEPTH)) || do_pop);
   assign head_data  = mem[rd_ptr];
   assign head_valid = (count != '0);
   assign occupancy  = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/memcore_uram_stream_reader.sv
// rtl/memcore_uram_stream_reader.sv - burst reader turning memcore read-port data into a backpressured stream
// Define MEMCORE_URAM_STREAM_READER_LAST_EN to add the dout_last end-of-burst marker.
module memcore_uram_stream_reader
   import memcore_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int ADDRESS_RANGE = 64,
   parameter int LEN_WIDTH     = 7,
   parameter int READ_LATENCY  = 1,
   parameter int BUF_DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]     req_len,
   input  logic                     req_valid,
   output logic                     req_ready,
   output logic [ADDRESS_WIDTH-1:0] address1,
   output logic                     ce1,
   input  logic [DATA_WIDTH-1:0]    q1,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     busy
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
   ,
   output logic                     dout_last
`endif
);
   localparam bit CFG_OK = buf_depth_ok(BUF_DEPTH, READ_LATENCY);
   localparam int CW     = $clog2(BUF_DEPTH) + 1;
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
   localparam int BW = DATA_WIDTH + 1;
`else
   localparam int BW = DATA_WIDTH;
`endif

   if (!CFG_OK) begin : g_cfg_error
      $error("memcore_uram_stream_reader: BUF_DEPTH/READ_LATENCY combination is illegal");
   end

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]     remaining;
   logic [READ_LATENCY-1:0]  pipe_v;
   logic [CW-1:0]            occupancy;
   logic [CW-1:0]            inflight;
   logic [CW:0]              credit_used;
   logic                     issue;
   logic                     pop;
   logic                     burst_done;
   logic [BW-1:0]            push_data;
   logic [BW-1:0]            head_data;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pipe_v[i]);
   end

   // Credits count reads still in the memcore pipe, so every return has a slot waiting.
   assign credit_used = {1'b0, inflight} + {1'b0, occupancy};
   assign issue       = (state == BURST) && (remaining != '0) && (credit_used < (CW+1)'(BUF_DEPTH));
   assign ce1         = issue;
   assign address1    = cur_addr;
   assign pop         = dout_valid && dout_ready;
   assign burst_done  = (remaining == '0) && (pipe_v == '0) &&
                        ((occupancy == '0) || ((occupancy == CW'(1)) && pop));
   assign req_ready   = (state != BURST);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE, DRAIN_DONE: begin
               state <= IDLE;
               if (req_valid && (req_len != '0)) begin
                  cur_addr  <= req_addr;
                  remaining <= req_len;
                  state     <= BURST;
               end
            end
            BURST: begin
               if (issue) begin
                  cur_addr  <= ADDRESS_WIDTH'(addr_next(32'(cur_addr), ADDRESS_RANGE));
                  remaining <= remaining - LEN_WIDTH'(1);
               end
               if (burst_done) state <= DRAIN_DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_v <= '0;
      end else begin
         pipe_v[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
      end
   end

`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
   logic [READ_LATENCY-1:0] pipe_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_last <= '0;
      end else begin
         pipe_last[0] <= issue && (remaining == LEN_WIDTH'(1));
         for (int i = 1; i < READ_LATENCY; i++) pipe_last[i] <= pipe_last[i-1];
      end
   end

   assign push_data         = {pipe_last[READ_LATENCY-1], q1};
   assign {dout_last, dout} = head_data;
`else
   assign push_data = q1;
   assign dout      = head_data;
`endif

   memcore_stream_buf #(
      .DATA_WIDTH (BW),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (pipe_v[READ_LATENCY-1]),
      .push_data  (push_data),
      .pop        (pop),
      .head_data  (head_data),
      .head_valid (dout_valid),
      .occupancy  (occupancy)
   );

endmodule

// File: tb/tb_memcore_uram_stream_reader.sv
// tb/tb_memcore_uram_stream_reader.sv - directed self-checking bench for memcore_uram_stream_reader
module tb_memcore_uram_stream_reader;
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
   localparam int RL = 3;
`else
   localparam int RL = 1;
`endif
   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [5:0]  req_addr;
   logic [6:0]  req_len;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  address1;
   logic        ce1;
   logic [31:0] q1;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        busy;
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
   logic        dout_last;
   int          got_last [$];
`endif

   int tests = 0;
   int fails = 0;
   int got [$];
   int iss [$];
   int first_k, last_k, max_out, hold_bad, done;

   logic [31:0] ram   [64];
   logic [31:0] mpipe [RL];

   memcore_uram_stream_reader #(
      .READ_LATENCY (RL),
      .BUF_DEPTH    (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .address1   (address1),
      .ce1        (ce1),
      .q1         (q1),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .busy       (busy)
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
      ,
      .dout_last  (dout_last)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memcore read port model; reads without ce1 return a poison pattern.
   always @(posedge clk) begin
      mpipe[0] <= ce1 ? ram[address1] : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
   end
   assign q1 = mpipe[RL-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_burst(input int addr, input int len, input int stall_at, input int stall_cyc);
      int k, issued, consumed;
      logic [31:0] held;
      got.delete();
      iss.delete();
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
      got_last.delete();
`endif
      first_k = -1; last_k = -1; max_out = 0; hold_bad = 0; done = 0;
      issued = 0; consumed = 0; held = '0;
      req_addr   = 6'(addr);
      req_len    = 7'(len);
      req_valid  = 1'b1;
      dout_ready = 1'b1;
      check("req_ready_before_accept", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (k < 300) begin
         if (last_k >= 0 && got.size() == len && k == last_k + 1) begin
            check("req_ready_after_last", req_ready, 1);
            done = 1;
            break;
         end
         dout_ready = !(k >= stall_at && k < stall_at + stall_cyc);
         if (ce1) begin
            iss.push_back(int'(address1));
            issued++;
            if (issued - consumed > max_out) max_out = issued - consumed;
         end
         if (dout_valid && !dout_ready) begin
            if (k > stall_at && held !== dout) hold_bad++;
            held = dout;
         end
         if (dout_valid && dout_ready) begin
            if (first_k < 0) first_k = k;
            got.push_back(int'(dout));
`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
            got_last.push_back(int'(dout_last));
`endif
            consumed++;
            last_k = k;
         end
         @(negedge clk);
         k++;
      end
      dout_ready = 1'b1;
      check("burst_completed", done, 1);
   endtask

   initial begin
      int quiet_bad;
      for (int i = 0; i < 64; i++) ram[i] = 32'(i + 100);
      reset = 1'b1; req_addr = '0; req_len = '0; req_valid = 1'b0; dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_req_ready", req_ready, 1);
      check("rst_ce1", ce1, 0);
      check("rst_address1", address1, 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_dout", dout, 0);
      check("rst_busy", busy, 0);

      // Basic burst at full rate.
      run_burst(5, 8, 1000, 0);
      check("b1_first_latency", first_k, RL + 1);
      check("b1_count", got.size(), 8);
      for (int i = 0; i < 8; i++) check($sformatf("b1_word%0d", i), got[i], 105 + i);
      check("b1_credit_bound", max_out <= DEPTH, 1);
`ifndef MEMCORE_URAM_STREAM_READER_LAST_EN
      check("b1_back_to_back", last_k - first_k, 7);
`endif
      @(negedge clk);
      check("b1_idle_busy", busy, 0);

      // Address wrap at the top of the memcore.
      run_burst(62, 4, 1000, 0);
      check("wrap_issue_count", iss.size(), 4);
      check("wrap_addr0", iss[0], 62);
      check("wrap_addr1", iss[1], 63);
      check("wrap_addr2", iss[2], 0);
      check("wrap_addr3", iss[3], 1);
      check("wrap_count", got.size(), 4);
      check("wrap_word0", got[0], 162);
      check("wrap_word1", got[1], 163);
      check("wrap_word2", got[2], 100);
      check("wrap_word3", got[3], 101);
      @(negedge clk);

      // Backpressure mid-burst for 10 cycles.
      run_burst(30, 16, 5, 10);
      check("bp_credit_reached", max_out, DEPTH);
      check("bp_hold_stable", hold_bad, 0);
      check("bp_count", got.size(), 16);
      for (int i = 0; i < 16; i++) check($sformatf("bp_word%0d", i), got[i], 130 + i);
      check("bp_issue_count", iss.size(), 16);
      @(negedge clk);

      // Zero-length request is accepted and does nothing.
      req_addr = 6'd9; req_len = 7'd0; req_valid = 1'b1;
      check("len0_req_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      quiet_bad = 0;
      repeat (10) begin
         if (ce1 || dout_valid || !req_ready || busy) quiet_bad++;
         @(negedge clk);
      end
      check("len0_quiet", quiet_bad, 0);

      // Asynchronous reset in the middle of a burst.
      req_addr = 6'd10; req_len = 7'd16; req_valid = 1'b1; dout_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("arst_pre_valid", dout_valid, 1);
      check("arst_pre_busy", busy, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_dout_valid", dout_valid, 0);
      check("arst_ce1", ce1, 0);
      check("arst_busy", busy, 0);
      check("arst_req_ready", req_ready, 1);
      @(negedge clk);
      #3 reset = 1'b0;
      @(negedge clk);
      run_burst(0, 2, 1000, 0);
      check("arst_count", got.size(), 2);
      check("arst_word0", got[0], 100);
      check("arst_word1", got[1], 101);
      quiet_bad = 0;
      repeat (8) begin
         if (dout_valid) quiet_bad++;
         @(negedge clk);
      end
      check("arst_no_residue", quiet_bad, 0);

`ifdef MEMCORE_URAM_STREAM_READER_LAST_EN
      run_burst(20, 3, 1000, 0);
      check("last_count", got.size(), 3);
      check("last_flag0", got_last[0], 0);
      check("last_flag1", got_last[1], 0);
      check("last_flag2", got_last[2], 1);
      check("last_word2", got[2], 122);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
